// File: rtl/uart_pkg.sv
// Shared encodings and the baud divisor helper for the UART transmit path.
package uart_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int unsigned baud_rate(input logic [1:0] sel);
    case (sel)
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // Nearest-integer clocks per bit.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned rate;
    rate = baud_rate(sel);
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; a push while full is
// rejected even if a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   cnt,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is flushed by the pointer/count reset, so it needs none itself.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop serialiser.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a queued word
//   ST_START  | start bit (0) for one bit period
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit, only when parity was enabled at frame start
//   ST_STOP   | STOP_BITS stop bits; chains straight into the next frame if queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  baudsel,
  input  logic [1:0]                  par_sel,
  input  logic [DATA_W-1:0]           d_in,
  input  logic                        load,
  output logic                        ready,
  output logic                        tx_out,
  output logic                        tx_status,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        overflow
);

  localparam int unsigned DIV_9600   = baud_div(CLK_HZ, BAUD_9600);
  localparam int unsigned DIV_19200  = baud_div(CLK_HZ, BAUD_19200);
  localparam int unsigned DIV_57600  = baud_div(CLK_HZ, BAUD_57600);
  localparam int unsigned DIV_115200 = baud_div(CLK_HZ, BAUD_115200);
  localparam int DIV_W = $clog2(DIV_9600 + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]  div_m1_q, div_m1_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              tx_status_q, tx_status_d;
  logic              overflow_q, overflow_d;

  logic [DIV_W-1:0]  div_sel_m1;
  logic              baud_tc;
  logic              next_frame;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (load),
    .push_data (d_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .cnt       (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ready     = !fifo_full;
  assign tx_out    = tx_q;
  assign tx_status = tx_status_q;
  assign overflow  = overflow_q;
  assign baud_tc   = (baud_cnt_q == '0);

  always_comb begin
    case (baudsel)
      BAUD_9600:  div_sel_m1 = DIV_W'(DIV_9600 - 1);
      BAUD_19200: div_sel_m1 = DIV_W'(DIV_19200 - 1);
      BAUD_57600: div_sel_m1 = DIV_W'(DIV_57600 - 1);
      default:    div_sel_m1 = DIV_W'(DIV_115200 - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_m1_d   = div_m1_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    next_frame = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) next_frame = 1'b1;
      end
      ST_START: begin
        if (baud_tc) begin
          state_d    = ST_DATA;
          baud_cnt_d = div_m1_q;
          bit_cnt_d  = BIT_W'(DATA_W - 1);
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          baud_cnt_d = div_m1_q;
          if (bit_cnt_q == '0) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
            end else begin
              state_d   = ST_STOP;
              bit_cnt_d = BIT_W'(STOP_BITS - 1);
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_tc) begin
          state_d    = ST_STOP;
          baud_cnt_d = div_m1_q;
          bit_cnt_d  = BIT_W'(STOP_BITS - 1);
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          if (bit_cnt_q == '0) begin
            if (!fifo_empty) next_frame = 1'b1;
            else             state_d    = ST_IDLE;
          end else begin
            baud_cnt_d = div_m1_q;
            bit_cnt_d  = bit_cnt_q - BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Baud and parity are sampled only here, so mid-frame changes wait for the next word.
    if (next_frame) begin
      fifo_pop   = 1'b1;
      state_d    = ST_START;
      shift_d    = fifo_rd;
      div_m1_d   = div_sel_m1;
      baud_cnt_d = div_sel_m1;
      par_en_d   = (par_sel == PAR_EVEN) || (par_sel == PAR_ODD);
      par_bit_d  = (par_sel == PAR_ODD) ? ~^fifo_rd : ^fifo_rd;
    end
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
    tx_status_d = !fifo_empty || (load && ready) ||
                  (state_q != ST_IDLE) || (state_d != ST_IDLE);
    overflow_d  = load && fifo_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      div_m1_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      tx_q        <= 1'b1;
      tx_status_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      div_m1_q    <= div_m1_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      tx_q        <= tx_d;
      tx_status_q <= tx_status_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. CLK_HZ=1_152_000 gives divisors 120/60/20/10
// so frames stay short; a second instance covers DATA_W=7, STOP_BITS=2.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] a_baud, a_par;
  logic [7:0] a_din;
  logic       a_load, a_ready, a_tx, a_status, a_ovf;
  logic [3:0] a_cnt;

  logic [1:0] b_baud, b_par;
  logic [6:0] b_din;
  logic       b_load, b_ready, b_tx, b_status, b_ovf;
  logic [3:0] b_cnt;

  uart_tx_fifo #(.CLK_HZ(1_152_000), .DATA_W(8), .FIFO_DEPTH(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .baudsel(a_baud), .par_sel(a_par), .d_in(a_din), .load(a_load),
    .ready(a_ready), .tx_out(a_tx), .tx_status(a_status), .fifo_cnt(a_cnt), .overflow(a_ovf)
  );

  uart_tx_fifo #(.CLK_HZ(1_152_000), .DATA_W(7), .FIFO_DEPTH(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .baudsel(b_baud), .par_sel(b_par), .d_in(b_din), .load(b_load),
    .ready(b_ready), .tx_out(b_tx), .tx_status(b_status), .fifo_cnt(b_cnt), .overflow(b_ovf)
  );

  logic [8:0] cap_data;
  logic       cap_par, cap_start, cap_stop;
  int         cap_t0;

  function automatic logic txs(input bit b);
    return b ? b_tx : a_tx;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] w);
    a_din = w; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  // Waits for a start bit, then samples every bit at its midpoint.
  task automatic capture(input bit b, input int div, input int nd, input bit pe, input int ns);
    int n, off, total;
    cap_data = 'x; cap_par = 1'bx; cap_start = 1'bx; cap_stop = 1'bx;
    n = 0;
    while (txs(b) !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (txs(b) !== 1'b0) begin cap_t0 = -100000; return; end
    cap_t0 = cyc; off = 0; cap_stop = 1'b1;
    total = 1 + nd + (pe ? 1 : 0) + ns;
    for (int p = 0; p < total; p++) begin
      while (off < p * div + div / 2) begin @(negedge clk); off++; end
      if (p == 0)                 cap_start = txs(b);
      else if (p <= nd)           cap_data[p-1] = txs(b);
      else if (pe && p == nd + 1) cap_par = txs(b);
      else                        cap_stop = cap_stop & txs(b);
    end
  endtask

  task automatic wait_idle_a;
    int n = 0;
    while (a_status !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_tx !== 1'b1)     begin n_err++; $display("FAIL reset_tx got %b want 1", a_tx); end
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL reset_status got %b want 0", a_status); end
    n_cmp++; if (a_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got %b want 1", a_ready); end
    n_cmp++; if (a_cnt !== 4'd0)    begin n_err++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
    n_cmp++; if (a_ovf !== 1'b0)    begin n_err++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    n_cmp++; if (b_tx !== 1'b1)     begin n_err++; $display("FAIL reset_b_tx got %b want 1", b_tx); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_baseline;
    a_baud = 2'b00; a_par = 2'b00;
    push_a(8'h0F);
    n_cmp++; if (a_cnt !== 4'd1)    begin n_err++; $display("FAIL base_cnt1 got %0d want 1", a_cnt); end
    n_cmp++; if (a_tx !== 1'b1)     begin n_err++; $display("FAIL base_lat_n got %b want 1", a_tx); end
    n_cmp++; if (a_status !== 1'b1) begin n_err++; $display("FAIL base_status_up got %b want 1", a_status); end
    @(negedge clk);
    n_cmp++; if (a_cnt !== 4'd0)    begin n_err++; $display("FAIL base_pop got %0d want 0", a_cnt); end
    n_cmp++; if (a_tx !== 1'b1)     begin n_err++; $display("FAIL base_lat_n1 got %b want 1", a_tx); end
    @(negedge clk);
    n_cmp++; if (a_tx !== 1'b0)     begin n_err++; $display("FAIL base_lat_n2 got %b want 0", a_tx); end
    capture(1'b0, 120, 8, 1'b0, 1);
    n_cmp++; if (cap_data[7:0] !== 8'h0F) begin n_err++; $display("FAIL base_data got %h want 0f", cap_data[7:0]); end
    n_cmp++; if (cap_start !== 1'b0) begin n_err++; $display("FAIL base_start got %b want 0", cap_start); end
    n_cmp++; if (cap_stop !== 1'b1)  begin n_err++; $display("FAIL base_stop got %b want 1", cap_stop); end
    wait_until(cap_t0 + 1199);
    n_cmp++; if (a_status !== 1'b1) begin n_err++; $display("FAIL base_len_busy got %b want 1", a_status); end
    wait_until(cap_t0 + 1200);
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL base_len_done got %b want 0", a_status); end
  endtask

  task automatic test_parity;
    logic [1:0] psel [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    logic [7:0] word [4] = '{8'h0F, 8'h0F, 8'h07, 8'h0F};
    logic       pexp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit         pen  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int         len;
    a_baud = 2'b11;
    for (int i = 0; i < 4; i++) begin
      a_par = psel[i];
      len = pen[i] ? 110 : 100;
      push_a(word[i]);
      capture(1'b0, 10, 8, pen[i], 1);
      n_cmp++; if (cap_data[7:0] !== word[i]) begin n_err++; $display("FAIL par_data[%0d] got %h want %h", i, cap_data[7:0], word[i]); end
      if (pen[i]) begin
        n_cmp++; if (cap_par !== pexp[i]) begin n_err++; $display("FAIL par_bit[%0d] got %b want %b", i, cap_par, pexp[i]); end
      end
      n_cmp++; if (cap_stop !== 1'b1) begin n_err++; $display("FAIL par_stop[%0d] got %b want 1", i, cap_stop); end
      wait_until(cap_t0 + len - 1);
      n_cmp++; if (a_status !== 1'b1) begin n_err++; $display("FAIL par_len_busy[%0d] got %b want 1", i, a_status); end
      wait_until(cap_t0 + len);
      n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL par_len_done[%0d] got %b want 0", i, a_status); end
    end
  endtask

  task automatic test_back_to_back;
    int t_prev;
    logic [7:0] exp;
    a_baud = 2'b00; a_par = 2'b00;
    push_a(8'h3C);
    capture(1'b0, 120, 8, 1'b0, 1);
    n_cmp++; if (cap_data[7:0] !== 8'h3C) begin n_err++; $display("FAIL b2b_first got %h want 3c", cap_data[7:0]); end
    for (int i = 0; i < 9; i++) begin
      a_din = 8'(17 * (i + 1)); a_load = 1'b1;
      @(negedge clk);
      if (i == 7) begin
        n_cmp++; if (a_cnt !== 4'd8)  begin n_err++; $display("FAIL b2b_cnt8 got %0d want 8", a_cnt); end
        n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready got %b want 0", a_ready); end
        n_cmp++; if (a_ovf !== 1'b0)  begin n_err++; $display("FAIL b2b_ovf_early got %b want 0", a_ovf); end
      end
      if (i == 8) begin
        n_cmp++; if (a_ovf !== 1'b1)  begin n_err++; $display("FAIL b2b_ovf got %b want 1", a_ovf); end
        n_cmp++; if (a_cnt !== 4'd8)  begin n_err++; $display("FAIL b2b_cnt_hold got %0d want 8", a_cnt); end
      end
    end
    a_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_pulse got %b want 0", a_ovf); end
    t_prev = cap_t0;
    for (int k = 0; k < 8; k++) begin
      exp = 8'(17 * (k + 1));
      capture(1'b0, 120, 8, 1'b0, 1);
      n_cmp++; if (cap_data[7:0] !== exp) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", k, cap_data[7:0], exp); end
      n_cmp++; if (cap_t0 - t_prev !== 1200) begin n_err++; $display("FAIL b2b_gap[%0d] got %0d want 1200", k, cap_t0 - t_prev); end
      t_prev = cap_t0;
    end
    wait_until(t_prev + 1200);
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", a_status); end
    n_cmp++; if (a_cnt !== 4'd0)    begin n_err++; $display("FAIL b2b_cnt_end got %0d want 0", a_cnt); end
  endtask

  task automatic test_baud_change;
    int t1;
    a_baud = 2'b00; a_par = 2'b00;
    push_a(8'h5A);
    @(negedge clk);
    a_baud = 2'b11; a_din = 8'hC3; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    capture(1'b0, 120, 8, 1'b0, 1);
    n_cmp++; if (cap_data[7:0] !== 8'h5A) begin n_err++; $display("FAIL baud_old_data got %h want 5a", cap_data[7:0]); end
    t1 = cap_t0;
    capture(1'b0, 10, 8, 1'b0, 1);
    n_cmp++; if (cap_data[7:0] !== 8'hC3) begin n_err++; $display("FAIL baud_new_data got %h want c3", cap_data[7:0]); end
    n_cmp++; if (cap_t0 - t1 !== 1200)   begin n_err++; $display("FAIL baud_old_len got %0d want 1200", cap_t0 - t1); end
    wait_until(cap_t0 + 100);
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL baud_new_len got %b want 0", a_status); end
  endtask

  task automatic test_reset_mid;
    int n_low;
    wait_idle_a();
    a_baud = 2'b00; a_par = 2'b00;
    push_a(8'h00); push_a(8'h01); push_a(8'h02); push_a(8'h03);
    repeat (400) @(negedge clk);
    n_cmp++; if (a_tx !== 1'b0)  begin n_err++; $display("FAIL rmid_pre_tx got %b want 0", a_tx); end
    n_cmp++; if (a_cnt !== 4'd3) begin n_err++; $display("FAIL rmid_pre_cnt got %0d want 3", a_cnt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_tx !== 1'b1)     begin n_err++; $display("FAIL rmid_tx got %b want 1", a_tx); end
    n_cmp++; if (a_cnt !== 4'd0)    begin n_err++; $display("FAIL rmid_cnt got %0d want 0", a_cnt); end
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL rmid_status got %b want 0", a_status); end
    n_cmp++; if (a_ready !== 1'b1)  begin n_err++; $display("FAIL rmid_ready got %b want 1", a_ready); end
    @(negedge clk);
    rst = 1'b0;
    n_low = 0;
    repeat (2000) begin @(negedge clk); if (a_tx !== 1'b1) n_low++; end
    n_cmp++; if (n_low !== 0)       begin n_err++; $display("FAIL rmid_silent got %0d low cycles want 0", n_low); end
    n_cmp++; if (a_status !== 1'b0) begin n_err++; $display("FAIL rmid_idle got %b want 0", a_status); end
  endtask

  task automatic test_seven_bit_two_stop;
    b_baud = 2'b11; b_par = 2'b00;
    b_din = 7'h55; b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    capture(1'b1, 10, 7, 1'b0, 2);
    n_cmp++; if (cap_data[6:0] !== 7'h55) begin n_err++; $display("FAIL b7_data got %h want 55", cap_data[6:0]); end
    n_cmp++; if (cap_start !== 1'b0) begin n_err++; $display("FAIL b7_start got %b want 0", cap_start); end
    n_cmp++; if (cap_stop !== 1'b1)  begin n_err++; $display("FAIL b7_stop got %b want 1", cap_stop); end
    wait_until(cap_t0 + 99);
    n_cmp++; if (b_status !== 1'b1) begin n_err++; $display("FAIL b7_len_busy got %b want 1", b_status); end
    wait_until(cap_t0 + 100);
    n_cmp++; if (b_status !== 1'b0) begin n_err++; $display("FAIL b7_len_done got %b want 0", b_status); end
  endtask

  initial begin
    rst = 1'b1;
    a_baud = 2'b00; a_par = 2'b00; a_din = '0; a_load = 1'b0;
    b_baud = 2'b00; b_par = 2'b00; b_din = '0; b_load = 1'b0;
    test_reset();
    test_baseline();
    test_parity();
    test_back_to_back();
    test_baud_change();
    test_reset_mid();
    test_seven_bit_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
